// File: rtl/tx_pulser_ch.sv
// tx_pulser_ch: per-channel transmit beamformer.
// On fire, looks up the focal delay for the selected scan line in a local LUT, waits that many
// clocks, then drives a bipolar burst (pulse_p then pulse_n, num_cycles periods of
// 2*half_period clocks each) to the HV pulser.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   lut_addr/we/din     delay LUT write port (any state)
//   line_sel            scan line, sampled on an accepted fire
//   fire                one-clock start strobe (ignored unless idle)
//   abort               synchronous abort of the current transmit
//   num_cycles          burst length in full periods, sampled on fire
//   half_period         clocks per half period, sampled on fire
//   pulse_p, pulse_n    registered bipolar drive, never both high
//   tx_en               high from FETCH through the last pulse clock
//   tx_done             one-clock strobe after the last pulse clock
module tx_pulser_ch #(
    parameter int unsigned ADDR_WD = 7,
    parameter int unsigned DLY_WD  = 12,
    parameter int unsigned CYC_WD  = 4,
    parameter int unsigned HP_WD   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_WD-1:0] lut_addr,
    input  logic               lut_we,
    input  logic [DLY_WD-1:0]  lut_din,
    input  logic [ADDR_WD-1:0] line_sel,
    input  logic               fire,
    input  logic               abort,
    input  logic [CYC_WD-1:0]  num_cycles,
    input  logic [HP_WD-1:0]   half_period,
    output logic               pulse_p,
    output logic               pulse_n,
    output logic               tx_en,
    output logic               tx_done
);

    typedef enum logic [2:0] {StIdle, StFetch, StDelay, StPulse, StDone} state_e;

    state_e              state_q, state_d;
    logic [DLY_WD-1:0]   lut_mem [2**ADDR_WD];
    logic [DLY_WD-1:0]   rd_q;
    logic [CYC_WD-1:0]   nc_q, cyc_cnt_q, cyc_cnt_d;
    logic [HP_WD-1:0]    hp_q, hp_cnt_q, hp_cnt_d;
    logic [DLY_WD-1:0]   dly_cnt_q, dly_cnt_d;
    logic                phase_q, phase_d;  // 0: positive half, 1: negative half
    logic                start;
    logic                zero_burst;
    logic                pulse_p_d, pulse_n_d, tx_en_d, tx_done_d;

    assign start      = (state_q == StIdle) && fire && !abort;
    assign zero_burst = (nc_q == '0) || (hp_q == '0);

    // The LUT is read on the accepting fire edge, addressed straight from line_sel, so the data
    // is valid during FETCH. Any write landing in FETCH (same address included) therefore only
    // affects later fires. Contents survive reset.
    always_ff @(posedge clk) begin
        if (lut_we) begin
            lut_mem[lut_addr] <= lut_din;
        end
        if (start) begin
            rd_q <= lut_mem[line_sel];
        end
    end

    always_comb begin
        state_d   = state_q;
        dly_cnt_d = dly_cnt_q;
        hp_cnt_d  = hp_cnt_q;
        cyc_cnt_d = cyc_cnt_q;
        phase_d   = phase_q;

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch, StDelay: begin
                // Leaving FETCH with D=0, or DELAY on its last count, goes straight to the burst.
                if ((state_q == StFetch && rd_q == '0) ||
                    (state_q == StDelay && dly_cnt_q == DLY_WD'(1))) begin
                    if (zero_burst) begin
                        state_d = StDone;
                    end else begin
                        state_d   = StPulse;
                        hp_cnt_d  = hp_q;
                        cyc_cnt_d = nc_q;
                        phase_d   = 1'b0;
                    end
                end else if (state_q == StFetch) begin
                    state_d   = StDelay;
                    dly_cnt_d = rd_q;
                end else begin
                    dly_cnt_d = dly_cnt_q - DLY_WD'(1);
                end
            end
            StPulse: begin
                if (hp_cnt_q != HP_WD'(1)) begin
                    hp_cnt_d = hp_cnt_q - HP_WD'(1);
                end else if (!phase_q) begin
                    phase_d  = 1'b1;
                    hp_cnt_d = hp_q;
                end else if (cyc_cnt_q == CYC_WD'(1)) begin
                    state_d = StDone;
                end else begin
                    phase_d   = 1'b0;
                    hp_cnt_d  = hp_q;
                    cyc_cnt_d = cyc_cnt_q - CYC_WD'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort && state_q != StIdle) begin
            state_d = StIdle;
        end

        // Outputs are registered from the next state so they line up with it.
        pulse_p_d = (state_d == StPulse) && !phase_d;
        pulse_n_d = (state_d == StPulse) && phase_d;
        tx_en_d   = (state_d == StFetch) || (state_d == StDelay) || (state_d == StPulse);
        tx_done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            nc_q      <= '0;
            hp_q      <= '0;
            dly_cnt_q <= '0;
            hp_cnt_q  <= '0;
            cyc_cnt_q <= '0;
            phase_q   <= 1'b0;
            pulse_p   <= 1'b0;
            pulse_n   <= 1'b0;
            tx_en     <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dly_cnt_q <= dly_cnt_d;
            hp_cnt_q  <= hp_cnt_d;
            cyc_cnt_q <= cyc_cnt_d;
            phase_q   <= phase_d;
            pulse_p   <= pulse_p_d;
            pulse_n   <= pulse_n_d;
            tx_en     <= tx_en_d;
            tx_done   <= tx_done_d;
            if (start) begin
                nc_q <= num_cycles;
                hp_q <= half_period;
            end
        end
    end

endmodule

// File: tb/tb_tx_pulser_ch.sv
// Self-checking bench for tx_pulser_ch. Each scenario pushes the expected per-clock output
// vector {tx_en, tx_done, pulse_p, pulse_n} into a scoreboard queue when it fires the channel,
// then pops and compares one entry per clock.
module tb_tx_pulser_ch;

    localparam int unsigned ADDR_WD = 7;
    localparam int unsigned DLY_WD  = 12;
    localparam int unsigned CYC_WD  = 4;
    localparam int unsigned HP_WD   = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [ADDR_WD-1:0] lut_addr;
    logic               lut_we;
    logic [DLY_WD-1:0]  lut_din;
    logic [ADDR_WD-1:0] line_sel;
    logic               fire;
    logic               abort;
    logic [CYC_WD-1:0]  num_cycles;
    logic [HP_WD-1:0]   half_period;
    logic               pulse_p, pulse_n, tx_en, tx_done;

    int          checks   = 0;
    int          failures = 0;
    logic [3:0]  sb[$];
    logic [3:0]  exp_v, obs_v;

    always #5 clk = ~clk;

    tx_pulser_ch #(
        .ADDR_WD(ADDR_WD), .DLY_WD(DLY_WD), .CYC_WD(CYC_WD), .HP_WD(HP_WD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .lut_addr(lut_addr), .lut_we(lut_we), .lut_din(lut_din),
        .line_sel(line_sel), .fire(fire), .abort(abort), .num_cycles(num_cycles),
        .half_period(half_period), .pulse_p(pulse_p), .pulse_n(pulse_n), .tx_en(tx_en),
        .tx_done(tx_done)
    );

    assign obs_v = {tx_en, tx_done, pulse_p, pulse_n};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fire   = 1'b0;
        abort  = 1'b0;
        lut_we = 1'b0;
        rst_n  = 1'b1;
    endtask

    task automatic lut_write(input int a, input int d);
        lut_addr = ADDR_WD'(a);
        lut_din  = DLY_WD'(d);
        lut_we   = 1'b1;
        tick();
        lut_we   = 1'b0;
    endtask

    // Expected trace from the clock after the fire edge: FETCH + D delay clocks with only tx_en,
    // the alternating burst, one tx_done clock, then idle.
    task automatic push_burst(input int d, input int nc, input int hp);
        for (int i = 0; i < 1 + d; i++) sb.push_back(4'b1000);
        if (nc != 0 && hp != 0) begin
            for (int c = 0; c < nc; c++) begin
                for (int i = 0; i < hp; i++) sb.push_back(4'b1010);
                for (int i = 0; i < hp; i++) sb.push_back(4'b1001);
            end
        end
        sb.push_back(4'b0100);
        sb.push_back(4'b0000);
        sb.push_back(4'b0000);
    endtask

    task automatic fire_line(input int l, input int nc, input int hp);
        line_sel    = ADDR_WD'(l);
        num_cycles  = CYC_WD'(nc);
        half_period = HP_WD'(hp);
        fire        = 1'b1;
        tick();
        fire        = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fire = 1'b0; abort = 1'b0; lut_we = 1'b0;
        lut_addr = '0; lut_din = '0; line_sel = '0; num_cycles = '0; half_period = '0;
        tick();
        tick();
        checks++;
        if (obs_v !== 4'b0000) begin
            failures++;
            $display("FAIL reset got=%b exp=0000", obs_v);
        end
        rst_n = 1'b1;
        tick();
    endtask

    // LUT[5]=10, nc=2, hp=3; a fire during the tx_done clock must be ignored.
    task automatic test_basic();
        lut_write(5, 10);
        fire_line(5, 2, 3);
        push_burst(10, 2, 3);
        for (int k = 1; sb.size() > 0; k++) begin
            idle_inputs();
            exp_v = sb.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL basic k=%0d got=%b exp=%b", k, obs_v, exp_v);
            end
            if (exp_v == 4'b0100) begin
                line_sel = 7'd5;
                fire = 1'b1;
            end
            tick();
        end
    endtask

    task automatic test_zero_delay();
        lut_write(0, 0);
        fire_line(0, 1, 1);
        push_burst(0, 1, 1);
        for (int k = 1; sb.size() > 0; k++) begin
            idle_inputs();
            exp_v = sb.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL zero_delay k=%0d got=%b exp=%b", k, obs_v, exp_v);
            end
            tick();
        end
        fire_line(0, 0, 4);
        push_burst(0, 0, 4);
        for (int k = 1; sb.size() > 0; k++) begin
            idle_inputs();
            exp_v = sb.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL zero_cycles k=%0d got=%b exp=%b", k, obs_v, exp_v);
            end
            tick();
        end
    endtask

    // Abort in the clock after the first pulse_p clock, then a normal fire.
    task automatic test_abort();
        fire_line(5, 2, 3);
        push_burst(10, 2, 3);
        for (int k = 1; sb.size() > 0; k++) begin
            idle_inputs();
            exp_v = sb.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL abort k=%0d got=%b exp=%b", k, obs_v, exp_v);
            end
            if (k == 13) begin
                abort = 1'b1;
                sb.delete();
                repeat (4) sb.push_back(4'b0000);
            end
            tick();
        end
        fire_line(5, 1, 1);
        push_burst(10, 1, 1);
        for (int k = 1; sb.size() > 0; k++) begin
            idle_inputs();
            exp_v = sb.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL after_abort k=%0d got=%b exp=%b", k, obs_v, exp_v);
            end
            tick();
        end
    endtask

    // One reset clock in the first pulse_n clock; LUT[5] must still hold 10.
    task automatic test_reset_mid_burst();
        fire_line(5, 2, 3);
        push_burst(10, 2, 3);
        for (int k = 1; sb.size() > 0; k++) begin
            idle_inputs();
            exp_v = sb.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL reset_mid k=%0d got=%b exp=%b", k, obs_v, exp_v);
            end
            if (k == 15) begin
                rst_n = 1'b0;
                sb.delete();
                repeat (3) sb.push_back(4'b0000);
            end
            tick();
        end
        fire_line(5, 1, 2);
        push_burst(10, 1, 2);
        for (int k = 1; sb.size() > 0; k++) begin
            idle_inputs();
            exp_v = sb.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL lut_kept k=%0d got=%b exp=%b", k, obs_v, exp_v);
            end
            tick();
        end
    endtask

    // Ignored second fire in DELAY; LUT writes during FETCH and mid-burst hit only the next fire.
    task automatic test_back_to_back();
        lut_write(0, 3);
        fire_line(5, 2, 3);
        push_burst(10, 2, 3);
        for (int k = 1; sb.size() > 0; k++) begin
            idle_inputs();
            exp_v = sb.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL ignore_fire k=%0d got=%b exp=%b", k, obs_v, exp_v);
            end
            if (k == 1) begin
                lut_addr = 7'd5; lut_din = 12'd7; lut_we = 1'b1;
            end
            if (k == 4) begin
                line_sel = 7'd0; num_cycles = 4'd1; half_period = 8'd2; fire = 1'b1;
            end
            if (k == 6) begin
                lut_addr = 7'd5; lut_din = 12'd20; lut_we = 1'b1;
            end
            tick();
        end
        fire_line(5, 1, 2);
        push_burst(20, 1, 2);
        for (int k = 1; sb.size() > 0; k++) begin
            idle_inputs();
            exp_v = sb.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL new_delay k=%0d got=%b exp=%b", k, obs_v, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_max_values();
        int first_p = 0;
        int done_k  = 0;
        int p_clks  = 0;
        lut_write(9, 4095);
        fire_line(9, 15, 255);
        push_burst(4095, 15, 255);
        for (int k = 1; sb.size() > 0; k++) begin
            idle_inputs();
            exp_v = sb.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL max k=%0d got=%b exp=%b", k, obs_v, exp_v);
            end
            checks++;
            if (pulse_p && pulse_n) begin
                failures++;
                $display("FAIL overlap k=%0d got=11 exp=not both", k);
            end
            if (pulse_p || pulse_n) p_clks++;
            if (pulse_p && first_p == 0) first_p = k;
            if (tx_done && done_k == 0) done_k = k;
            tick();
        end
        checks++;
        if (first_p != 4097) begin
            failures++;
            $display("FAIL max_first_p got=%0d exp=4097", first_p);
        end
        checks++;
        if (p_clks != 7650) begin
            failures++;
            $display("FAIL max_pulse_clks got=%0d exp=7650", p_clks);
        end
        checks++;
        if (done_k != 11747) begin
            failures++;
            $display("FAIL max_done got=%0d exp=11747", done_k);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_delay();
        test_abort();
        test_reset_mid_burst();
        test_back_to_back();
        test_max_values();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
